mem_port_arbiter: RTL

Shares one single-port unified memory between the core's instruction-fetch port and data (load/store) port. Each requester uses a req/ack handshake. The arbiter grants one requester at a time, drives the memory interface, waits for memory completion or timeout, and returns read data plus a one-cycle ack. It sits between the MIPS core and the external memory model, so the core can run multi-cycle against a realistic, variable-latency memory.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mem_port_arbiter_timeout.sv | 36 +++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner IDs,
// and the word-alignment mask.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Access watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
module mem_timeout_counter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry is seen during the last allowed cycle so the FSM leaves right after it.
   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory, with a
// data-burst limit so a pending fetch cannot starve.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned MAX_DATA_BURST = 4,
   parameter int unsigned TIMEOUT        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);
   import mips_pkg::*;

   localparam int unsigned    BURST_W   = $clog2(MAX_DATA_BURST + 1);
   localparam [BURST_W-1:0]   BURST_MAX = BURST_W'(MAX_DATA_BURST);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic              mem_en_q, mem_en_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              busy_q, busy_d;
   logic              grant_d, grant_if, to_resp;
   logic              tmo_clear, tmo_expired;

   mem_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (state_q == ST_ACCESS),
      .expired(tmo_expired)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      burst_d    = burst_q;
      mem_en_d   = mem_en_q;
      err_d      = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      grant_d    = 1'b0;
      grant_if   = 1'b0;
      to_resp    = 1'b0;
      tmo_clear  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            tmo_clear = 1'b1;
            grant_d   = d_req && (!if_req || (burst_q < BURST_MAX));
            grant_if  = !grant_d && if_req;
            if (!if_req) begin
               burst_d = '0;
            end
            if (grant_d) begin
               owner_d = OWN_D;
               we_d    = d_we;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               if (if_req && (burst_q < BURST_MAX)) begin
                  burst_d = burst_q + BURST_W'(1);
               end
            end else if (grant_if) begin
               owner_d = OWN_IF;
               we_d    = 1'b0;
               addr_d  = if_addr;
               wdata_d = '0;
               burst_d = '0;
            end
            if (grant_d || grant_if) begin
               if ((addr_d[1:0] & MISALIGN_MASK) != 2'b00) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  to_resp = 1'b1;
               end else begin
                  state_d  = ST_ACCESS;
                  mem_en_d = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_ready) begin
               if (!we_q) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     if_rdata_d = mem_rdata;
                  end
               end
               mem_en_d = 1'b0;
               state_d  = ST_RESP;
               to_resp  = 1'b1;
            end else if (tmo_expired) begin
               mem_en_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_RESP;
               to_resp  = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
         end
      endcase

      if_ack_d = to_resp && (owner_d == OWN_IF);
      d_ack_d  = to_resp && (owner_d == OWN_D);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         burst_q    <= '0;
         mem_en_q   <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         burst_q    <= burst_d;
         mem_en_q   <= mem_en_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         err_q      <= err_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         busy_q     <= busy_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign err       = err_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;

endmodule
